// File: rtl/approx_err_accum.sv
// Error characterisation for an approximate adder: streams (IN1, IN2, APPROX)
// samples and accumulates squared error, peak |error| and nonzero-error count.
module approx_err_accum #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 1024,
    parameter int ACC_W       = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   IN1,
    input  logic [WIDTH-1:0]   IN2,
    input  logic [WIDTH:0]     APPROX,
    output logic [ACC_W-1:0]   sse,
    output logic [WIDTH:0]     max_err,
    output logic [20:0]        err_count,
    output logic               overflow
);

    localparam int CNT_W = 21;
    localparam int SQ_W  = 2 * (WIDTH + 1);
    localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   sample_cnt;
    logic               drain_cnt;
    logic               done_first;
    logic               accept;
    logic               clear;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_in1, s1_in2;
    logic [WIDTH:0]     s1_approx;
    logic               s2_valid;
    logic [WIDTH:0]     s2_abs;

    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     abs_e;
    logic [SQ_W-1:0]    sq;
    logic [SUM_W-1:0]   sum;

    assign accept = in_valid && in_ready;
    assign clear  = start && (state == IDLE || state == DONE);

    // Difference is taken modulo 2^(WIDTH+2); its top bit is the sign of e.
    assign diff  = {2'b00, s1_in1} + {2'b00, s1_in2} - {1'b0, s1_approx};
    assign abs_e = diff[WIDTH+1] ? (WIDTH+1)'(-diff) : diff[WIDTH:0];
    assign sq    = SQ_W'(s2_abs) * SQ_W'(s2_abs);
    assign sum   = SUM_W'(sse) + SUM_W'(sq);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && sample_cnt == CNT_W'(NUM_SAMPLES - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_next = DONE;
            end
            DONE: begin
                done = done_first;
                if (start) state_next = ACCUM;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            drain_cnt  <= 1'b0;
            done_first <= 1'b0;
            s1_valid   <= 1'b0;
            s1_in1     <= '0;
            s1_in2     <= '0;
            s1_approx  <= '0;
            s2_valid   <= 1'b0;
            s2_abs     <= '0;
            sse        <= '0;
            max_err    <= '0;
            err_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            drain_cnt  <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            done_first <= (state == DRAIN) && drain_cnt;

            s1_valid <= accept;
            if (accept) begin
                s1_in1    <= IN1;
                s1_in2    <= IN2;
                s1_approx <= APPROX;
            end
            s2_valid <= s1_valid;
            s2_abs   <= abs_e;

            if (clear) begin
                sample_cnt <= '0;
                sse        <= '0;
                max_err    <= '0;
                err_count  <= '0;
                overflow   <= 1'b0;
            end else begin
                if (accept) sample_cnt <= sample_cnt + CNT_W'(1);
                if (s2_valid) begin
                    // Any bit above ACC_W in the wide sum means the accumulator would wrap.
                    if (|sum[SUM_W-1:ACC_W]) begin
                        sse      <= '1;
                        overflow <= 1'b1;
                    end else begin
                        sse <= sum[ACC_W-1:0];
                    end
                    if (s2_abs > max_err) max_err <= s2_abs;
                    if (s2_abs != '0) err_count <= err_count + 21'd1;
                end
            end
        end
    end

endmodule

// File: doc/approx_err_accum.md
APPROX_ERR_ACCUM -- requirements
Module: approx_err_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width of the characterised adder.
REQ-002 SHALL have parameter NUM_SAMPLES, default 1024, giving the samples per measurement run (legal range 1 to 2^20).
REQ-003 SHALL have parameter ACC_W, default 48, giving the width of the squared-error accumulator.
REQ-004 SHALL have one clock and a synchronous, active-high reset, on these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
REQ-005 SHALL have these run-control ports:
- start  input  1  one-cycle request to begin a run.
- busy  output  1  high in state ACCUM.
- done  output  1  one-cycle pulse when results become valid.
REQ-006 SHALL have these sample ports:
- in_valid  input  1  sample present.
- in_ready  output  1  sample can be accepted.
- IN1  input  WIDTH  adder operand A.
- IN2  input  WIDTH  adder operand B.
- APPROX  input  WIDTH+1  approximate adder output Out.
REQ-007 SHALL have these result ports:
- sse  output  ACC_W  sum of squared errors.
- max_err  output  WIDTH+1  largest absolute error.
- err_count  output  21  count of samples with nonzero error.
- overflow  output  1  sticky flag, set when sse saturates.

Function
REQ-008 SHALL implement FSM states IDLE, ACCUM, DRAIN and DONE.
REQ-009 SHALL, on start in IDLE or DONE, clear sse, max_err, err_count, overflow and the sample counter, then enter ACCUM on the next cycle.
REQ-010 SHALL ignore start while in ACCUM or DRAIN.
REQ-011 SHALL drive in_ready=1 only in ACCUM, and accept a sample in any cycle with in_valid and in_ready both high.
REQ-012 SHALL allow in_valid gaps, which only stall the run and cause no error.
REQ-013 SHALL compute, in stage 1 (the cycle after acceptance), e = ({1'b0,IN1}+{1'b0,IN2}) - APPROX as a signed WIDTH+2-bit value, and register |e| in WIDTH+1 bits.
REQ-014 SHALL, in stage 2 (the cycle after stage 1), add |e|^2 to sse, set max_err=max(max_err,|e|), and increment err_count if |e|!=0.
REQ-015 SHALL, when adding |e|^2 would exceed 2^ACC_W-1, saturate sse at all-ones and set overflow until the next start or rst.
REQ-016 SHALL move from ACCUM to DRAIN in the cycle after the NUM_SAMPLES-th acceptance, so in_ready drops immediately.
REQ-017 SHALL stay in DRAIN for exactly 2 cycles, then enter DONE and assert done for exactly that first DONE cycle.
REQ-018 SHALL therefore assert done 3 cycles after the last accepted sample (last acceptance at cycle t gives done at cycle t+3).
REQ-019 SHALL hold sse, max_err, err_count and overflow stable from done until the next start or rst.
REQ-020 SHALL clear results in the cycle a start arrives in DONE, before any new sample is accepted.
REQ-021 SHALL output busy=1 in ACCUM only, and 0 in all other states.

Reset
REQ-022 SHALL, on rst, go to IDLE and drive in_ready, busy, done and overflow to 0 and sse, max_err and err_count to 0.
REQ-023 SHALL, on rst mid-run (ACCUM or DRAIN), discard all in-flight pipeline data and assert no done pulse.
REQ-024 SHALL give rst priority over start in the same cycle.

Verification
REQ-025 SHALL have a bench that, with NUM_SAMPLES=4, applies 4 samples with APPROX=IN1+IN2 exactly -> sse=0, max_err=0, err_count=0, done 3 cycles after the 4th accept.
REQ-026 SHALL have a bench that, with NUM_SAMPLES=4, applies IN1=0x00FF, IN2=0x0001, APPROX=0x00000 four times -> sse=262144, max_err=256, err_count=4.
REQ-027 SHALL have a bench that, with NUM_SAMPLES=1, applies IN1=0, IN2=0, APPROX=0x001FF (negative error) -> sse=261121, max_err=511, err_count=1.
REQ-028 SHALL have a bench that, with NUM_SAMPLES=4, toggles in_valid 1,0,0,1,1,0,1 -> exactly 4 accepts, results identical to the gap-free run, and in_ready=0 from the cycle after the 4th accept.
REQ-029 SHALL have a bench that, with ACC_W=18, applies two samples of |e|=511 -> sse=262143, overflow=1.
REQ-030 SHALL have a bench that asserts rst after 2 of 4 samples, then start -> no done from the aborted run, fresh run results counting only the new samples.
